// File: rtl/lu_pkg.sv
// Shared types for the logic-unit arbiter: opcode and FSM state encodings.
// Optional feature macro used by the top: LU_GRANT_COUNT_EN.
package lu_pkg;

  typedef enum logic [1:0] {
    LU_XOR = 2'b00,
    LU_AND = 2'b01,
    LU_OR  = 2'b10,
    LU_NOT = 2'b11
  } lu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } lu_state_e;

endpackage

// File: rtl/lu_core.sv
// Purely combinational bitwise logic unit; the single resource shared by all requesters.
module lu_core
  import lu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    out = '0;
    case (lu_op_e'(op))
      LU_XOR:  out = x ^ y;
      LU_AND:  out = x & y;
      LU_OR:   out = x | y;
      LU_NOT:  out = ~x;
      default: out = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one lu_core between NUM_REQ valid/ready requesters.
// Define LU_GRANT_COUNT_EN to add per-requester saturating grant counters (GRANT_CNT).
module logic_unit_arbiter
  import lu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NUM_REQ-1:0]         REQ_VALID,
  output logic [NUM_REQ-1:0]         REQ_READY,
  input  logic [2*NUM_REQ-1:0]       REQ_OP,
  input  logic [WIDTH*NUM_REQ-1:0]   REQ_X,
  input  logic [WIDTH*NUM_REQ-1:0]   REQ_Y,
  output logic                       RSP_VALID,
  input  logic                       RSP_READY,
  output logic [ID_W-1:0]            RSP_ID,
  output logic [WIDTH-1:0]           RSP_OUT
`ifdef LU_GRANT_COUNT_EN
  ,
  output logic [16*NUM_REQ-1:0]      GRANT_CNT
`endif
);

  lu_state_e        state, state_nxt;
  logic [ID_W-1:0]  last;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  scan_idx;
  logic             found;
  logic             accept;

  logic [1:0]       op_p0;
  logic [WIDTH-1:0] x_p0;
  logic [WIDTH-1:0] y_p0;
  logic [ID_W-1:0]  id_p0;
  logic [WIDTH-1:0] core_out;

  // Scan upward from last+1 with wrap; first valid index wins.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = ID_W'((int'(last) + k) % NUM_REQ);
      if (!found && REQ_VALID[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  assign accept = (state == IDLE) && found && !RST;

  always_comb begin
    state_nxt = state;
    REQ_READY = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          REQ_READY[winner] = 1'b1;
          state_nxt         = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (RSP_READY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      last  <= ID_W'(NUM_REQ - 1);
    end else begin
      state <= state_nxt;
      if (accept) last <= winner;
    end
  end

  // Stage p0: capture the winner's operands on accept.
  always_ff @(posedge CLK) begin
    if (accept) begin
      op_p0 <= REQ_OP[2*int'(winner) +: 2];
      x_p0  <= REQ_X[WIDTH*int'(winner) +: WIDTH];
      y_p0  <= REQ_Y[WIDTH*int'(winner) +: WIDTH];
      id_p0 <= winner;
    end
  end

  lu_core #(.WIDTH(WIDTH)) u_core (
    .op  (op_p0),
    .x   (x_p0),
    .y   (y_p0),
    .out (core_out)
  );

  // Response stage: register core result in EXEC, hold until handshake.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RSP_VALID <= 1'b0;
      RSP_OUT   <= '0;
      RSP_ID    <= '0;
    end else if (state == EXEC) begin
      RSP_VALID <= 1'b1;
      RSP_OUT   <= core_out;
      RSP_ID    <= id_p0;
    end else if (state == RESP && RSP_READY) begin
      RSP_VALID <= 1'b0;
    end
  end

`ifdef LU_GRANT_COUNT_EN
  logic [NUM_REQ-1:0][15:0] gnt_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      gnt_cnt <= '0;
    end else if (accept && gnt_cnt[winner] != 16'hFFFF) begin
      gnt_cnt[winner] <= gnt_cnt[winner] + 16'd1;
    end
  end

  assign GRANT_CNT = gnt_cnt;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter (NUM_REQ=4, WIDTH=8), hand-computed expectations.
module tb_logic_unit_arbiter;

  logic        CLK;
  logic        RST;
  logic [3:0]  REQ_VALID;
  logic [3:0]  REQ_READY;
  logic [7:0]  REQ_OP;
  logic [31:0] REQ_X;
  logic [31:0] REQ_Y;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [1:0]  RSP_ID;
  logic [7:0]  RSP_OUT;
`ifdef LU_GRANT_COUNT_EN
  logic [63:0] GRANT_CNT;
`endif

  int ncmp  = 0;
  int nfail = 0;

  logic_unit_arbiter #(.NUM_REQ(4), .WIDTH(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_OP    (REQ_OP),
    .REQ_X     (REQ_X),
    .REQ_Y     (REQ_Y),
    .RSP_VALID (RSP_VALID),
    .RSP_READY (RSP_READY),
    .RSP_ID    (RSP_ID),
    .RSP_OUT   (RSP_OUT)
`ifdef LU_GRANT_COUNT_EN
    ,
    .GRANT_CNT (GRANT_CNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
    REQ_OP[2*i +: 2] = op;
    REQ_X[8*i +: 8]  = x;
    REQ_Y[8*i +: 8]  = y;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Full transaction from IDLE with RSP_READY=1; returns in IDLE.
  task automatic xact(input string tag, input logic [3:0] vmask, input logic [1:0] exp_id,
                      input logic [7:0] exp_out);
    REQ_VALID = vmask;
    RSP_READY = 1'b1;
    #1;
    check({tag, ".ready"}, REQ_READY, 4'b0001 << exp_id);
    next_cycle();
    check({tag, ".exec_ready"}, REQ_READY, 4'b0000);
    check({tag, ".exec_valid"}, RSP_VALID, 1'b0);
    next_cycle();
    check({tag, ".rsp_valid"}, RSP_VALID, 1'b1);
    check({tag, ".rsp_id"}, RSP_ID, exp_id);
    check({tag, ".rsp_out"}, RSP_OUT, exp_out);
    check({tag, ".rsp_ready"}, REQ_READY, 4'b0000);
    next_cycle();
    check({tag, ".idle_valid"}, RSP_VALID, 1'b0);
  endtask

  task automatic reset_pulse();
    RST = 1'b1;
    #1;
    check("rst_pulse.valid", RSP_VALID, 1'b0);
    next_cycle();
    RST = 1'b0;
  endtask

  initial begin
    RST       = 1'b1;
    REQ_VALID = '0;
    REQ_OP    = '0;
    REQ_X     = '0;
    REQ_Y     = '0;
    RSP_READY = 1'b0;
    next_cycle();
    next_cycle();
    check("reset.rsp_valid", RSP_VALID, 1'b0);
    check("reset.rsp_out", RSP_OUT, 8'h00);
    check("reset.rsp_id", RSP_ID, 2'd0);
    check("reset.req_ready", REQ_READY, 4'b0000);
    RST = 1'b0;
    next_cycle();

    // Single request: A5 ^ 0F = AA
    set_req(0, 2'b00, 8'hA5, 8'h0F);
    xact("single", 4'b0001, 2'd0, 8'hAA);
    REQ_VALID = '0;

    // Round robin from reset: 0,1,2,3,0
    reset_pulse();
    for (int i = 0; i < 4; i++) set_req(i, 2'b00, 8'h10 | 8'(i), 8'h00);
    xact("rr0", 4'b1111, 2'd0, 8'h10);
    xact("rr1", 4'b1111, 2'd1, 8'h11);
    xact("rr2", 4'b1111, 2'd2, 8'h12);
    xact("rr3", 4'b1111, 2'd3, 8'h13);
    xact("rr4", 4'b1111, 2'd0, 8'h10);
    REQ_VALID = '0;

    // Opcode coverage on requester 2
    set_req(2, 2'b00, 8'hF0, 8'h3C);
    xact("op_xor", 4'b0100, 2'd2, 8'hCC);
    set_req(2, 2'b01, 8'hF0, 8'h3C);
    xact("op_and", 4'b0100, 2'd2, 8'h30);
    set_req(2, 2'b10, 8'hF0, 8'h3C);
    xact("op_or", 4'b0100, 2'd2, 8'hFC);
    set_req(2, 2'b11, 8'hF0, 8'h3C);
    xact("op_not", 4'b0100, 2'd2, 8'h0F);
    REQ_VALID = '0;

    // Backpressure: last=2, so requester 0 wins first, then 1
    set_req(0, 2'b10, 8'h12, 8'h21);
    set_req(1, 2'b01, 8'hFF, 8'h5A);
    REQ_VALID = 4'b0011;
    RSP_READY = 1'b0;
    #1;
    check("bp.ready", REQ_READY, 4'b0001);
    next_cycle();
    next_cycle();
    check("bp.rsp_valid", RSP_VALID, 1'b1);
    check("bp.rsp_out", RSP_OUT, 8'h33);
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      check("bp.hold_valid", RSP_VALID, 1'b1);
      check("bp.hold_out", RSP_OUT, 8'h33);
      check("bp.hold_id", RSP_ID, 2'd0);
      check("bp.hold_ready", REQ_READY, 4'b0000);
    end
    RSP_READY = 1'b1;
    next_cycle();
    check("bp.released", RSP_VALID, 1'b0);
    xact("bp.next", 4'b0011, 2'd1, 8'h5A);
    REQ_VALID = '0;

    // Reset in EXEC: no response, first grant after reset is requester 0
    set_req(3, 2'b11, 8'h3C, 8'h00);
    REQ_VALID = 4'b1000;
    #1;
    check("mid.ready", REQ_READY, 4'b1000);
    next_cycle();
    REQ_VALID = '0;
    RST = 1'b1;
    #1;
    check("mid.rst_valid", RSP_VALID, 1'b0);
    check("mid.rst_ready", REQ_READY, 4'b0000);
    next_cycle();
    RST = 1'b0;
    check("mid.after_valid", RSP_VALID, 1'b0);
    next_cycle();
    check("mid.no_rsp_valid", RSP_VALID, 1'b0);
    check("mid.no_rsp_out", RSP_OUT, 8'h00);
    set_req(0, 2'b00, 8'hA5, 8'h0F);
    xact("mid.first", 4'b1111, 2'd0, 8'hAA);
    REQ_VALID = '0;

`ifdef LU_GRANT_COUNT_EN
    reset_pulse();
    check("cnt.cleared", GRANT_CNT, 64'h0);
    set_req(1, 2'b00, 8'h01, 8'h02);
    xact("cnt.g1", 4'b0010, 2'd1, 8'h03);
    xact("cnt.g2", 4'b0010, 2'd1, 8'h03);
    xact("cnt.g3", 4'b0010, 2'd1, 8'h03);
    check("cnt.three", GRANT_CNT, 64'h0000_0000_0003_0000);
    force dut.gnt_cnt[1] = 16'hFFFF;
    #1;
    release dut.gnt_cnt[1];
    xact("cnt.sat", 4'b0010, 2'd1, 8'h03);
    check("cnt.saturated", GRANT_CNT[31:16], 16'hFFFF);
    REQ_VALID = '0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one WIDTH-bit bitwise logic unit (XOR/AND/OR/NOT) between NUM_REQ requesters.
- Requesters use a valid/ready handshake; arbitration is round-robin.
- Each granted operation is sequenced through capture, execute and response phases.
- The registered result is returned on a single response channel tagged with the requester ID.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand/result width in bits.
- ID_W, $clog2(NUM_REQ), requester ID width (derived; do not override).

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous, active-high reset
- REQ_VALID  input  NUM_REQ  per-requester request valid
- REQ_READY  output  NUM_REQ  per-requester accept strobe (one-hot or zero)
- REQ_OP  input  2*NUM_REQ  per-requester opcode, requester i at [2i+1:2i]
- REQ_X  input  WIDTH*NUM_REQ  per-requester operand X
- REQ_Y  input  WIDTH*NUM_REQ  per-requester operand Y
- RSP_VALID  output  1  result valid
- RSP_READY  input  1  consumer accepts result
- RSP_ID  output  ID_W  index of the requester that owns the result
- RSP_OUT  output  WIDTH  result

Behaviour:
- Opcodes:
  - 00 XOR: X^Y
  - 01 AND: X&Y
  - 10 OR: X|Y
  - 11 NOT: ~X, Y ignored
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any REQ_VALID is high, the winner is the first valid index scanning upward (with wrap) from LAST+1.
  - REQ_READY[winner] is asserted combinationally in that cycle only.
  - On the clock edge, op/X/Y/ID are captured, LAST is set to winner, and the FSM goes to EXEC.
  - With no valid requester: REQ_READY=0 and the FSM stays in IDLE.
- EXEC: the core output is registered into RSP_OUT/RSP_ID, RSP_VALID is set, and the FSM goes to RESP.
- RESP:
  - RSP_VALID=1; RSP_OUT and RSP_ID are held stable.
  - On RSP_VALID&&RSP_READY: RSP_VALID is cleared next edge and the FSM goes to IDLE.
  - No new grant is made in RESP.
- Timing:
  - Latency: accept at edge t, RSP_VALID high after edge t+1.
  - Minimum initiation interval: 3 cycles.
- REQ_READY is 0 in EXEC and RESP; at most one bit is ever high.
- Requester rules:
  - A requester holds VALID/operands until it sees READY.
  - Dropping VALID without READY is legal; that request is simply not granted.
- Reset values (RST high, async): state=IDLE, LAST=NUM_REQ-1 (so requester 0 wins first), RSP_VALID=0, RSP_OUT=0, RSP_ID=0, REQ_READY=0.
- Reset mid-operation: an in-flight result is discarded with no response; the first grant after reset follows the reset LAST value.
- Wrap-around: after LAST=NUM_REQ-1 the scan restarts at 0.
- Fairness: under persistent requests from all requesters, every requester is granted once per NUM_REQ grants.
- Simultaneous events: a request arriving in the same cycle as a RESP handshake waits for IDLE (one cycle later).

Optional Feature:
- Macro: LU_GRANT_COUNT_EN.
- When defined:
  - Adds output GRANT_CNT [16*NUM_REQ].
  - One 16-bit counter per requester increments on each of its grants, saturating at 16'hFFFF.
  - Counters clear on RST.
- When undefined: the port and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package lu_pkg: opcode enum (LU_XOR, LU_AND, LU_OR, LU_NOT, 2-bit) and FSM state enum (IDLE, EXEC, RESP).
- Sub-module lu_core: purely combinational WIDTH-bit logic unit, inputs op/X/Y, output OUT. It is the shared resource instantiated once.
- Arbitration, FSM and registers live in logic_unit_arbiter.

Test Plan:
- Reset and single request:
  - Stimulus: RST pulse, then REQ_VALID=0001, op=00, X=8'hA5, Y=8'h0F.
  - Response: REQ_READY=0001 for one cycle; RSP_VALID one cycle later with RSP_OUT=8'hAA, RSP_ID=0.
- Round-robin fairness:
  - Stimulus: REQ_VALID=1111 held, RSP_READY=1.
  - Response: grant order 0,1,2,3,0; exactly one READY bit per grant.
- Opcode coverage:
  - Stimulus: requester 2, X=8'hF0, Y=8'h3C, ops 00/01/10/11.
  - Response: RSP_OUT=8'hCC, 8'h30, 8'hFC, 8'h0F; RSP_ID=2.
- Backpressure:
  - Stimulus: RSP_READY=0 for 5 cycles with REQ_VALID=0011.
  - Response: RSP_VALID, RSP_OUT and RSP_ID stay stable; REQ_READY=0 throughout; the next grant goes to requester 1 after the handshake.
- Reset mid-operation:
  - Stimulus: assert RST in EXEC.
  - Response: RSP_VALID=0 immediately with no response emitted; the first post-reset grant goes to requester 0.
- LU_GRANT_COUNT_EN:
  - Stimulus: 3 grants to requester 1.
  - Response: GRANT_CNT[31:16]=3, all other counters 0; counter saturation checked at 16'hFFFF via force.
